// File: rtl/conv_pkg.sv
// Shared definitions for the convolution result writer: default sizes,
// writer FSM state encoding and the row/col -> linear address mapping.
// Optional build macro used by the writer: CONV_RESULT_WRITER_RELU_SAT_EN.
package conv_pkg;

  localparam int N_DEF          = 16;
  localparam int IMG_W_DEF      = 32;
  localparam int ADDR_W_DEF     = 10;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int TAG_W          = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } wr_state_t;

  // Row-major linear address; the caller truncates to its address width.
  function automatic int calc_addr(input logic [TAG_W-1:0] row,
                                   input logic [TAG_W-1:0] col,
                                   input int img_w);
    return int'({27'd0, row}) * img_w + int'({27'd0, col});
  endfunction

endpackage

// File: rtl/conv_result_writer_if.sv
// Bundles the result stream from the adder pipeline, the SRAM write port
// and the frame status outputs. slave = writer view, master = source/SRAM view.
interface conv_result_writer_if #(
  parameter int N      = 16,
  parameter int ADDR_W = 10
);

  logic                      din_valid;
  logic [N-1:0]              din;
  logic [conv_pkg::TAG_W-1:0] row_in;
  logic [conv_pkg::TAG_W-1:0] col_in;
  logic                      done_in;

  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [N-1:0]              mem_wdata;
  logic                      mem_ready;

  logic                      frame_done;
  logic                      overflow;
  logic [ADDR_W:0]           wr_count;

  modport slave (
    input  din_valid, din, row_in, col_in, done_in, mem_ready,
    output mem_we, mem_addr, mem_wdata, frame_done, overflow, wr_count
  );

  modport master (
    output din_valid, din, row_in, col_in, done_in, mem_ready,
    input  mem_we, mem_addr, mem_wdata, frame_done, overflow, wr_count
  );

endinterface

// File: rtl/result_fifo.sv
// Synchronous FIFO with push/pop, full/empty and occupancy count.
// Exposes the head entry and the one behind it so the consumer can refill
// its output register on the same edge it retires the head.
module result_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic [W-1:0]               next,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign head  = mem[rd_ptr];
  assign next  = mem[rd_ptr + AW'(1)];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/conv_result_writer.sv
// Writes 3x3 convolution results to the output feature-map SRAM at row*IMG_W+col.
// Latency: 2 cycles push-to-mem_we on an empty FIFO; 1 write/cycle sustained.
// Backpressure: mem_ready stalls are absorbed by the FIFO; a push into a full FIFO
// without a same-cycle write is dropped and flagged on the sticky overflow output.
// Build option: define CONV_RESULT_WRITER_RELU_SAT_EN to clamp negative results to 0.
module conv_result_writer
  import conv_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int IMG_W      = IMG_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  conv_result_writer_if.slave  bus
);

  localparam int EW = 1 + ADDR_W + N;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W:0] WR_SAT = {1'b1, {ADDR_W{1'b0}}};

  logic [N-1:0]      push_data;
  logic [ADDR_W-1:0] push_addr;
  logic [EW-1:0]     push_entry;
  logic              push;
  logic              drop;
  logic              fire;
  logic              frame_start;

  logic [EW-1:0]     head;
  logic [EW-1:0]     next;
  logic              empty;
  logic              full;
  logic [CW-1:0]     count;

  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [N-1:0]      mem_wdata_q;
  logic              out_done_q;
  logic              overflow_q;
  logic              frame_done_q;
  logic [ADDR_W:0]   wr_count_q;
  logic              tail_seen;
  wr_state_t         state;

`ifdef CONV_RESULT_WRITER_RELU_SAT_EN
  assign push_data = bus.din[N-1] ? '0 : bus.din;
`else
  assign push_data = bus.din;
`endif

  assign push_addr  = ADDR_W'(calc_addr(bus.row_in, bus.col_in, IMG_W));
  assign push_entry = {bus.done_in, push_addr, push_data};

  // The head is only retired when the SRAM takes it, so a full FIFO can
  // still accept a push in the same cycle a write fires.
  assign fire        = mem_we_q & bus.mem_ready;
  assign push        = bus.din_valid & (~full | fire);
  assign drop        = bus.din_valid & full & ~fire;
  assign frame_start = bus.din_valid & ((state == IDLE) | (state == DONE));

  result_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_entry),
    .pop      (fire),
    .head     (head),
    .next     (next),
    .empty    (empty),
    .full     (full),
    .count    (count)
  );

  // Output register mirrors the FIFO head: refill from the second entry on a
  // fired write, or from the head when the stage is idle; hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      out_done_q  <= 1'b0;
    end else if (fire) begin
      if (count >= CW'(2)) begin
        mem_we_q                              <= 1'b1;
        {out_done_q, mem_addr_q, mem_wdata_q} <= next;
      end else begin
        mem_we_q <= 1'b0;
      end
    end else if (!mem_we_q && !empty) begin
      mem_we_q                              <= 1'b1;
      {out_done_q, mem_addr_q, mem_wdata_q} <= head;
    end
  end

  // Sticky drop indicator, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       overflow_q <= 1'b0;
    else if (drop) overflow_q <= 1'b1;
  end

  // Frame FSM with registered frame_done pulse and per-frame write counter.
  // tail_seen records that the frame's last result was written or dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      frame_done_q <= 1'b0;
      wr_count_q   <= '0;
      tail_seen    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;

      if (frame_start) begin
        wr_count_q <= fire ? (ADDR_W+1)'(1) : '0;
        tail_seen  <= drop & bus.done_in;
      end else begin
        if (fire && (wr_count_q != WR_SAT)) wr_count_q <= wr_count_q + (ADDR_W+1)'(1);
        if ((fire && out_done_q) || (drop && bus.done_in)) tail_seen <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.din_valid) state <= bus.done_in ? DRAIN : RUN;
        end
        RUN: begin
          if (bus.din_valid && bus.done_in) state <= DRAIN;
        end
        DRAIN: begin
          if (empty && !mem_we_q && tail_seen) begin
            state        <= DONE;
            frame_done_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.din_valid) state <= bus.done_in ? DRAIN : RUN;
          else               state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.frame_done = frame_done_q;
  assign bus.overflow   = overflow_q;
  assign bus.wr_count   = wr_count_q;

endmodule

// File: tb/tb_conv_result_writer.sv
// Scoreboard bench for conv_result_writer: directed frames push expected
// {addr,data} pairs; a negedge monitor checks every fired SRAM write.
module tb_conv_result_writer;

  localparam int N  = 16;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_result_writer_if #(.N(N), .ADDR_W(AW)) bus();

  conv_result_writer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int fires    = 0;
  int fd_count = 0;
  int fd_cyc   = 0;
  int last_fire_cyc = 0;

  logic [AW+N-1:0] exp_q[$];
  logic [N-1:0]    d101;
  logic            stalled_prev = 1'b0;
  logic [AW-1:0]   st_addr = '0;
  logic [N-1:0]    st_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [N-1:0] relu_model(input logic [N-1:0] d);
`ifdef CONV_RESULT_WRITER_RELU_SAT_EN
    return d[N-1] ? '0 : d;
`else
    return d;
`endif
  endfunction

  // Monitor: scoreboard pop on each fired write, stall-hold check, frame_done tracking.
  always @(negedge clk) begin
    if (rst) begin
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev && bus.mem_we)
        check("stall_hold", 64'({bus.mem_addr, bus.mem_wdata}), 64'({st_addr, st_data}));
      stalled_prev = bus.mem_we && !bus.mem_ready;
      st_addr      = bus.mem_addr;
      st_data      = bus.mem_wdata;
      if (bus.mem_we && bus.mem_ready) begin
        fires++;
        last_fire_cyc = cyc;
        if (bus.mem_addr == AW'(101)) d101 = bus.mem_wdata;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: addr=0x%0h data=0x%0h, scoreboard empty",
                   bus.mem_addr, bus.mem_wdata);
        end else begin
          check("write", 64'({bus.mem_addr, bus.mem_wdata}), 64'(exp_q.pop_front()));
        end
      end
      if (bus.frame_done) begin
        fd_count++;
        fd_cyc = cyc;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [4:0] r, input logic [4:0] c, input logic [N-1:0] d,
                      input logic dn, input logic expect_it);
    logic [AW-1:0] a;
    a = AW'(32 * int'(r) + int'(c));
    bus.din_valid = 1'b1;
    bus.row_in    = r;
    bus.col_in    = c;
    bus.din       = d;
    bus.done_in   = dn;
    if (expect_it) exp_q.push_back({a, relu_model(d)});
    step(1);
    bus.din_valid = 1'b0;
    bus.done_in   = 1'b0;
  endtask

  task automatic wait_fd(input string name, input int budget);
    int start;
    int k;
    start = fd_count;
    k = 0;
    while (fd_count == start && k < budget) begin
      step(1);
      k++;
    end
    check(name, 64'(fd_count != start), 64'd1);
  endtask

  int fd0;
  int f0;

  initial begin
    rst           = 1'b1;
    bus.din_valid = 1'b0;
    bus.din       = '0;
    bus.row_in    = '0;
    bus.col_in    = '0;
    bus.done_in   = 1'b0;
    bus.mem_ready = 1'b0;
    d101          = '0;
    step(3);
    @(negedge clk);
    check("rst_mem_we",     64'(bus.mem_we),     64'd0);
    check("rst_mem_addr",   64'(bus.mem_addr),   64'd0);
    check("rst_mem_wdata",  64'(bus.mem_wdata),  64'd0);
    check("rst_frame_done", 64'(bus.frame_done), 64'd0);
    check("rst_overflow",   64'(bus.overflow),   64'd0);
    check("rst_wr_count",   64'(bus.wr_count),   64'd0);
    step(1);
    rst = 1'b0;

    // 1: reset mid-stream with 3 entries queued
    bus.mem_ready = 1'b0;
    push(5'd1, 5'd1, 16'h0011, 1'b0, 1'b0);
    push(5'd1, 5'd2, 16'h0022, 1'b0, 1'b0);
    push(5'd1, 5'd3, 16'h0033, 1'b0, 1'b0);
    step(1);
    check("t1_we_before_rst", 64'(bus.mem_we), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("t1_async_we",    64'(bus.mem_we),    64'd0);
    check("t1_async_addr",  64'(bus.mem_addr),  64'd0);
    check("t1_async_wdata", 64'(bus.mem_wdata), 64'd0);
    step(2);
    rst = 1'b0;
    bus.mem_ready = 1'b1;
    f0 = fires;
    step(6);
    check("t1_no_write_after_rst", 64'(fires - f0), 64'd0);
    check("t1_we_idle", 64'(bus.mem_we), 64'd0);

    // 2: full 32x32 frame at full rate
    fd0 = fd_count;
    for (int i = 0; i < 1024; i++)
      push(5'(i / 32), 5'(i % 32), 16'(i * 5 + 7), logic'(i == 1023), 1'b1);
    wait_fd("t2_frame_done", 60);
    check("t2_done_latency", 64'(fd_cyc - last_fire_cyc), 64'd2);
    check("t2_wr_count", 64'(bus.wr_count), 64'd1024);
    check("t2_sb_empty", 64'(exp_q.size()), 64'd0);
    check("t2_addr101_data", 64'(d101), 64'h0200);
    step(4);
    check("t2_single_pulse", 64'(fd_count - fd0), 64'd1);

    // 5: sign handling of a negative result
    push(5'd0, 5'd1, 16'h8001, 1'b0, 1'b1);
    push(5'd0, 5'd2, 16'h1234, 1'b1, 1'b1);
    wait_fd("t5_frame_done", 30);
    check("t5_sb_empty", 64'(exp_q.size()), 64'd0);

    // 3: six stall cycles during eight pushes
    for (int i = 0; i < 8; i++) begin
      bus.mem_ready = (i >= 1 && i <= 6) ? 1'b0 : 1'b1;
      push(5'd2, 5'(i), 16'(16'h0100 + i), logic'(i == 7), 1'b1);
    end
    bus.mem_ready = 1'b1;
    wait_fd("t3_frame_done", 40);
    check("t3_overflow", 64'(bus.overflow), 64'd0);
    check("t3_wr_count", 64'(bus.wr_count), 64'd8);
    check("t3_sb_empty", 64'(exp_q.size()), 64'd0);

    // 6: done_in pushed into a full FIFO while a write fires
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 8; i++)
      push(5'd4, 5'(i), 16'(16'h0200 + i), 1'b0, 1'b1);
    step(1);
    check("t6_full_no_drop", 64'(bus.overflow), 64'd0);
    bus.mem_ready = 1'b1;
    push(5'd4, 5'd8, 16'h0208, 1'b1, 1'b1);
    check("t6_push_accepted", 64'(bus.overflow), 64'd0);
    wait_fd("t6_frame_done", 40);
    check("t6_wr_count", 64'(bus.wr_count), 64'd9);
    check("t6_sb_empty", 64'(exp_q.size()), 64'd0);
    step(2);

    // 4: ninth push with stalled SRAM is dropped (and carries done_in)
    bus.mem_ready = 1'b0;
    push(5'd5, 5'd0, 16'h0300, 1'b0, 1'b1);
    check("t4_wr_count_restart", 64'(bus.wr_count), 64'd0);
    for (int i = 1; i < 8; i++)
      push(5'd5, 5'(i), 16'(16'h0300 + i), 1'b0, 1'b1);
    check("t4_no_drop_at_8", 64'(bus.overflow), 64'd0);
    push(5'd5, 5'd8, 16'h0308, 1'b1, 1'b0);
    check("t4_overflow_set", 64'(bus.overflow), 64'd1);
    step(3);
    bus.mem_ready = 1'b1;
    wait_fd("t4_frame_done", 40);
    check("t4_wr_count", 64'(bus.wr_count), 64'd8);
    check("t4_sb_empty", 64'(exp_q.size()), 64'd0);
    step(3);
    check("t4_overflow_sticky", 64'(bus.overflow), 64'd1);

    rst = 1'b1;
    #1;
    check("final_rst_overflow", 64'(bus.overflow), 64'd0);
    check("final_rst_wr_count", 64'(bus.wr_count), 64'd0);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
